wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Write-port arbiter directly upstream of the register file.
- Merges two write sources onto the register file's single write port (`writeEn`/`dest`/`writeVal`):
  - the in-order pipeline writeback (MEM/WB result, highest priority, never back-pressured);
  - a long-latency unit result stream (multiply/divide, custom instructions) that is buffered in a small FIFO.
- Exports a pending-destination mask so the hazard unit can stall reads of registers whose writes are still queued.

Parameters:
- WORD_LEN, 32, data width of a register value.
- ADDR_LEN, 5, register address width (32 registers).
- DEPTH, 4, FIFO entries for long-latency results; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before hold request (optional feature only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wbEn  in  1  pipeline writeback valid.
- wbDest  in  ADDR_LEN  pipeline destination register.
- wbVal  in  WORD_LEN  pipeline writeback value.
- lvValid  in  1  long-latency result valid.
- lvDest  in  ADDR_LEN  long-latency destination.
- lvVal  in  WORD_LEN  long-latency value.
- lvReady  out  1  FIFO can accept this cycle.
- writeEn  out  1  register file write enable.
- dest  out  ADDR_LEN  register file write address.
- writeVal  out  WORD_LEN  register file write data.
- pendMask  out  2**ADDR_LEN  bit r set while any queued entry targets register r.
- qCount  out  clog2(DEPTH)+1  number of occupied FIFO entries.
- wbHold  out  1  request that the pipeline present wbEn=0 next cycle (optional feature only).

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; read and write pointers = 0; qCount = 0; pendMask = 0.
  - wbHold = 0; starvation counter = 0.
  - lvReady = 1 once rst deasserts.
  - Reset mid-operation discards all queued entries; no writes are issued while rst = 0.
- Write port, combinational, zero latency; the register file samples it on the negedge of the same cycle:
  - wbEffective = wbEn and wbDest != 0.
  - If wbEffective: writeEn=1, dest=wbDest, writeVal=wbVal.
  - Else if FIFO non-empty: writeEn=1, dest/writeVal = FIFO head; the head is popped at the next posedge.
  - Else: writeEn=0, dest=0, writeVal=0.
- Enqueue:
  - lvReady = (qCount < DEPTH), computed from registered state only. A pop in the same cycle does not free a slot for that cycle.
  - Enqueue occurs at posedge when lvValid and lvReady and lvDest != 0.
  - lvDest = 0 results are accepted (handshake completes) and discarded.
  - lvValid while lvReady = 0: producer must hold its data stable; nothing is dropped.
- Simultaneous push and pop: pointers both advance and qCount is unchanged.
- Pointers: ADDR width clog2(DEPTH); they wrap naturally modulo DEPTH.
- qCount: range 0..DEPTH inclusive; never overflows or underflows.
- pendMask: OR over valid entries of one-hot(dest), derived from registered FIFO contents. An entry being popped this cycle still shows in pendMask until the posedge.
- Ordering:
  - FIFO entries drain in arrival order.
  - A pipeline write always wins over the queue head; the queue is never reordered.
  - WAW between the pipeline and a queued entry is prevented upstream by the hazard unit via pendMask; this block does not check it.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- When defined:
  - A counter increments each cycle the FIFO is non-empty and wbEffective=1, and clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT-1, wbHold is registered to 1 for exactly one cycle and the counter clears.
  - The pipeline guarantees wbEn=0 during the cycle wbHold=1, so the head drains that cycle.
  - wbHold never asserts while the FIFO is empty.
- When undefined: wbHold is tied to 0, no counter is instantiated, and the queue drains only in pipeline-idle cycles.

Test Plan:
- Reset then wbEn=1, wbDest=3, wbVal=0x12345678 -> same cycle writeEn=1, dest=3, writeVal=0x12345678; qCount=0, pendMask=0.
- lvValid=1, lvDest=7, lvVal=0xA5 with wbEn=0 -> next cycle qCount=1, pendMask[7]=1, writeEn=1, dest=7; following cycle qCount=0, pendMask=0.
- Four lv pushes to regs 1..4 while wbEn=1 every cycle -> qCount=4, lvReady=0, pendMask=0x1E. Drop wbEn -> writes issued to 1, 2, 3, 4 in order on four consecutive cycles.
- Full FIFO, lvValid=1 held, one pop -> push accepted only on the cycle after qCount reads 3; no entry lost or duplicated.
- wbDest=0 and lvDest=0 writes -> writeEn stays 0; qCount unchanged; lvReady handshake completes.
- With WB_STARVE_GUARD_EN, STARVE_LIMIT=8, one queued entry and wbEn=1 continuously -> wbHold=1 after 8 blocked cycles. Bench drives wbEn=0 that cycle -> entry drains; wbHold returns to 0.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - write-port arbiter bus: pipeline writeback, long-latency stream, regfile port
interface wb_write_arbiter_if #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int DEPTH    = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     wbEn;
    logic [ADDR_LEN-1:0]      wbDest;
    logic [WORD_LEN-1:0]      wbVal;
    logic                     lvValid;
    logic [ADDR_LEN-1:0]      lvDest;
    logic [WORD_LEN-1:0]      lvVal;
    logic                     lvReady;
    logic                     writeEn;
    logic [ADDR_LEN-1:0]      dest;
    logic [WORD_LEN-1:0]      writeVal;
    logic [(2**ADDR_LEN)-1:0] pendMask;
    logic [CNT_W-1:0]         qCount;
    logic                     wbHold;

    modport master (
        output wbEn, wbDest, wbVal, lvValid, lvDest, lvVal,
        input  lvReady, writeEn, dest, writeVal, pendMask, qCount, wbHold
    );

    modport slave (
        input  wbEn, wbDest, wbVal, lvValid, lvDest, lvVal,
        output lvReady, writeEn, dest, writeVal, pendMask, qCount, wbHold
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - regfile write-port arbiter with long-latency FIFO; optional WB_STARVE_GUARD_EN
module wb_write_arbiter #(
    parameter int WORD_LEN     = 32,
    parameter int ADDR_LEN     = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_write_arbiter_if.slave    bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NREG   = 2 ** ADDR_LEN;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 2) begin : g_param_check
        $error("wb_write_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 2");
    end

    logic [ADDR_LEN-1:0] dest_mem_q [DEPTH];
    logic [WORD_LEN-1:0] val_mem_q  [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NREG-1:0]     pend_mask;

    logic wb_eff;
    logic fifo_empty;
    logic lv_ready;
    logic push;
    logic pop;

    assign wb_eff     = bus.wbEn && (bus.wbDest != '0);
    assign fifo_empty = (count_q == '0);
    assign lv_ready   = rst && (count_q < CNT_W'(DEPTH));
    // lvDest == 0 still completes the handshake but never occupies a slot
    assign push       = bus.lvValid && lv_ready && (bus.lvDest != '0);
    assign pop        = rst && !wb_eff && !fifo_empty;

    always_comb begin
        bus.writeEn  = 1'b0;
        bus.dest     = '0;
        bus.writeVal = '0;
        if (rst) begin
            if (wb_eff) begin
                bus.writeEn  = 1'b1;
                bus.dest     = bus.wbDest;
                bus.writeVal = bus.wbVal;
            end else if (!fifo_empty) begin
                bus.writeEn  = 1'b1;
                bus.dest     = dest_mem_q[rd_ptr_q];
                bus.writeVal = val_mem_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] offset;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(offset) < count_q) begin
                pend_mask[dest_mem_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem_q[wr_ptr_q] <= bus.lvDest;
            val_mem_q[wr_ptr_q]  <= bus.lvVal;
        end
    end

    assign bus.lvReady  = lv_ready;
    assign bus.qCount   = count_q;
    assign bus.pendMask = pend_mask;

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;

    // Hold fires on the blocked cycle that finds the counter already at the limit
    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (!fifo_empty && wb_eff) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                hold_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.wbHold = hold_q;
`else
    assign bus.wbHold = 1'b0;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - table-driven bench for wb_write_arbiter
module tb_wb_write_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    wb_write_arbiter_if #(.WORD_LEN(32), .ADDR_LEN(5), .DEPTH(4)) bus ();

    wb_write_arbiter #(
        .WORD_LEN(32), .ADDR_LEN(5), .DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_dest;
        logic [31:0] wb_val;
        logic        lv_valid;
        logic [4:0]  lv_dest;
        logic [31:0] lv_val;
        logic        e_we;
        logic [4:0]  e_dest;
        logic [31:0] e_val;
        logic [2:0]  e_q;
        logic [31:0] e_mask;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic we, input logic [4:0] wd, input logic [31:0] wv,
                                input logic lv, input logic [4:0] ld, input logic [31:0] lval,
                                input logic ewe, input logic [4:0] ed, input logic [31:0] ev,
                                input logic [2:0] eq, input logic [31:0] em, input logic er);
        vec_t v;
        v.wb_en = we;   v.wb_dest = wd; v.wb_val = wv;
        v.lv_valid = lv; v.lv_dest = ld; v.lv_val = lval;
        v.e_we = ewe;   v.e_dest = ed;  v.e_val = ev;
        v.e_q = eq;     v.e_mask = em;  v.e_rdy = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wv,
                         input logic lv, input logic [4:0] ld, input logic [31:0] lval);
        bus.wbEn = we;    bus.wbDest = wd; bus.wbVal = wv;
        bus.lvValid = lv; bus.lvDest = ld; bus.lvVal = lval;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  dr_dest [4];
        logic [31:0] dr_val  [4];
        int          hold_cycle;

        n_vec = 0;
        n_err = 0;

        //              wbEn wbD wbVal         lvV lvD lvVal        we  dest wVal          q  mask          rdy
        tbl[0]  = mk(0, 0,  32'h0,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);
        tbl[1]  = mk(1, 3,  32'h12345678, 0, 0,  32'h0,     1, 3,  32'h12345678, 0, 32'h0,        1);
        tbl[2]  = mk(0, 0,  32'h0,        1, 7,  32'hA5,    0, 0,  32'h0,        0, 32'h0,        1);
        tbl[3]  = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 7,  32'hA5,       1, 32'h80,       1);
        tbl[4]  = mk(0, 0,  32'h0,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);
        tbl[5]  = mk(1, 5,  32'h55,       1, 1,  32'h11,    1, 5,  32'h55,       0, 32'h0,        1);
        tbl[6]  = mk(1, 6,  32'h66,       1, 2,  32'h22,    1, 6,  32'h66,       1, 32'h2,        1);
        tbl[7]  = mk(1, 8,  32'h88,       1, 3,  32'h33,    1, 8,  32'h88,       2, 32'h6,        1);
        tbl[8]  = mk(1, 9,  32'h99,       1, 4,  32'h44,    1, 9,  32'h99,       3, 32'hE,        1);
        tbl[9]  = mk(1, 10, 32'hAA,       0, 0,  32'h0,     1, 10, 32'hAA,       4, 32'h1E,       0);
        tbl[10] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 1,  32'h11,       4, 32'h1E,       0);
        tbl[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 2,  32'h22,       3, 32'h1C,       1);
        tbl[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 3,  32'h33,       2, 32'h18,       1);
        tbl[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 4,  32'h44,       1, 32'h10,       1);
        tbl[14] = mk(0, 0,  32'h0,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);
        tbl[15] = mk(1, 0,  32'hDEAD,     1, 0,  32'hBEEF,  0, 0,  32'h0,        0, 32'h0,        1);
        tbl[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);
        tbl[17] = mk(0, 4,  32'h1,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);
        tbl[18] = mk(0, 0,  32'h0,        1, 31, 32'hFF,    0, 0,  32'h0,        0, 32'h0,        1);
        tbl[19] = mk(1, 0,  32'h1234,     0, 0,  32'h0,     1, 31, 32'hFF,       1, 32'h80000000, 1);
        tbl[20] = mk(0, 0,  32'h0,        0, 0,  32'h0,     0, 0,  32'h0,        0, 32'h0,        1);

        rst = 1'b0;
        drive(1, 3, 32'h77, 1, 5, 32'h5);
        @(negedge clk);
        chk("reset_writeEn", 64'(bus.writeEn), 64'(0));
        chk("reset_qCount", 64'(bus.qCount), 64'(0));
        chk("reset_pendMask", 64'(bus.pendMask), 64'(0));
        chk("reset_wbHold", 64'(bus.wbHold), 64'(0));
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].wb_en, tbl[i].wb_dest, tbl[i].wb_val,
                  tbl[i].lv_valid, tbl[i].lv_dest, tbl[i].lv_val);
            @(negedge clk);
            chk($sformatf("v%0d_writeEn", i), 64'(bus.writeEn), 64'(tbl[i].e_we));
            chk($sformatf("v%0d_dest", i), 64'(bus.dest), 64'(tbl[i].e_dest));
            chk($sformatf("v%0d_writeVal", i), 64'(bus.writeVal), 64'(tbl[i].e_val));
            chk($sformatf("v%0d_qCount", i), 64'(bus.qCount), 64'(tbl[i].e_q));
            chk($sformatf("v%0d_pendMask", i), 64'(bus.pendMask), 64'(tbl[i].e_mask));
            chk($sformatf("v%0d_lvReady", i), 64'(bus.lvReady), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_wbHold", i), 64'(bus.wbHold), 64'(0));
            next_cycle();
        end

        // Full FIFO with lvValid held across a single pop
        for (int k = 0; k < 4; k++) begin
            drive(1, 10, 32'(k), 1, 5'(11 + k), 32'h100 + 32'(k));
            next_cycle();
        end
        drive(1, 10, 32'h0, 1, 15, 32'h10F);
        @(negedge clk);
        chk("full_lvReady", 64'(bus.lvReady), 64'(0));
        chk("full_qCount", 64'(bus.qCount), 64'(4));
        chk("full_pendMask", 64'(bus.pendMask), 64'h7800);
        next_cycle();
        bus.wbEn = 1'b0;
        @(negedge clk);
        chk("popcyc_lvReady", 64'(bus.lvReady), 64'(0));
        chk("popcyc_dest", 64'(bus.dest), 64'(11));
        chk("popcyc_writeVal", 64'(bus.writeVal), 64'h100);
        next_cycle();
        bus.wbEn = 1'b1;
        @(negedge clk);
        chk("after_pop_qCount", 64'(bus.qCount), 64'(3));
        chk("after_pop_lvReady", 64'(bus.lvReady), 64'(1));
        next_cycle();
        bus.lvValid = 1'b0;
        @(negedge clk);
        chk("refill_qCount", 64'(bus.qCount), 64'(4));
        chk("refill_pendMask", 64'(bus.pendMask), 64'hF000);
        next_cycle();
        dr_dest = '{5'd12, 5'd13, 5'd14, 5'd15};
        dr_val  = '{32'h101, 32'h102, 32'h103, 32'h10F};
        bus.wbEn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_writeEn", k), 64'(bus.writeEn), 64'(1));
            chk($sformatf("drain%0d_dest", k), 64'(bus.dest), 64'(dr_dest[k]));
            chk($sformatf("drain%0d_writeVal", k), 64'(bus.writeVal), 64'(dr_val[k]));
            next_cycle();
        end
        @(negedge clk);
        chk("drained_qCount", 64'(bus.qCount), 64'(0));
        chk("drained_writeEn", 64'(bus.writeEn), 64'(0));
        next_cycle();

        // Reset in the middle of operation discards the queue
        drive(0, 0, 0, 1, 9, 32'h99);
        next_cycle();
        drive(1, 3, 32'h3, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_qCount", 64'(bus.qCount), 64'(0));
        chk("midrst_pendMask", 64'(bus.pendMask), 64'(0));
        chk("midrst_writeEn", 64'(bus.writeEn), 64'(0));
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("postrst_lvReady", 64'(bus.lvReady), 64'(1));
        chk("postrst_qCount", 64'(bus.qCount), 64'(0));
        chk("postrst_writeEn", 64'(bus.writeEn), 64'(0));
        next_cycle();

        // One queued entry behind a pipeline that writes every cycle
        drive(1, 1, 32'h1, 1, 20, 32'h2020);
        next_cycle();
        bus.lvValid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        hold_cycle = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.wbHold) begin
                hold_cycle = k;
                bus.wbEn = 1'b0;
                break;
            end
            bus.wbEn = 1'b1;
            next_cycle();
        end
        chk("starve_hold_cycle", 64'(hold_cycle), 64'(9));
        @(negedge clk);
        chk("starve_writeEn", 64'(bus.writeEn), 64'(1));
        chk("starve_dest", 64'(bus.dest), 64'(20));
        chk("starve_writeVal", 64'(bus.writeVal), 64'h2020);
        next_cycle();
        bus.wbEn = 1'b1;
        @(negedge clk);
        chk("starve_hold_clear", 64'(bus.wbHold), 64'(0));
        chk("starve_qCount", 64'(bus.qCount), 64'(0));
        next_cycle();
`else
        hold_cycle = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.wbHold) hold_cycle = k;
            chk($sformatf("blocked%0d_qCount", k), 64'(bus.qCount), 64'(1));
            next_cycle();
        end
        chk("noguard_hold_cycle", 64'(hold_cycle), 64'(0));
        bus.wbEn = 1'b0;
        @(negedge clk);
        chk("noguard_dest", 64'(bus.dest), 64'(20));
        next_cycle();
        @(negedge clk);
        chk("noguard_qCount", 64'(bus.qCount), 64'(0));
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
